// File: rtl/ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_reg
// Purpose  : EX/Mem pipeline register for the uP16 5-stage core. Carries the
//            Mem/WB control bits, ALU result, store data, RF destination and
//            ALU status from EX to Mem, with stall hold, flush-to-bubble, a
//            valid bit, forwarding-hit detection back toward EX and saturating
//            stall/bubble event counters.
// Ports    : Clk, Rst            - clock, synchronous active-high reset
//            stall, flush        - hold / bubble request from hazard unit
//            valid_i             - EX holds a real instruction
//            sel_mem2Reg, RFwriteEnab, memWriteEnab, memEnab - EX controls
//            ALUresult, storeData, RFdest_rd, ALUstatus      - EX data
//            src_rs, src_rt      - EX source addresses for forwarding compare
//            cnt_clr             - clear both performance counters
//            valid_o, *_o        - registered stage contents
//            fwd_rs_hit, fwd_rt_hit - combinational forwarding match
//            stall_cnt, bubble_cnt  - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage_reg #(
    parameter int DSIZE   = 16,
    parameter int RSIZE   = 3,
    parameter int SSIZE   = 4,
    parameter int CSIZE   = 16,
    parameter int R0_ZERO = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_i,
    input  logic             sel_mem2Reg,
    input  logic             RFwriteEnab,
    input  logic             memWriteEnab,
    input  logic             memEnab,
    input  logic [DSIZE-1:0] ALUresult,
    input  logic [DSIZE-1:0] storeData,
    input  logic [RSIZE-1:0] RFdest_rd,
    input  logic [SSIZE-1:0] ALUstatus,
    input  logic [RSIZE-1:0] src_rs,
    input  logic [RSIZE-1:0] src_rt,
    input  logic             cnt_clr,
    output logic             valid_o,
    output logic             sel_mem2Reg_o,
    output logic             RFwriteEnab_o,
    output logic             memWriteEnab_o,
    output logic             memEnab_o,
    output logic [DSIZE-1:0] ALUresult_o,
    output logic [DSIZE-1:0] storeData_o,
    output logic [RSIZE-1:0] RFdest_rd_o,
    output logic [SSIZE-1:0] ALUstatus_o,
    output logic             fwd_rs_hit,
    output logic             fwd_rt_hit,
    output logic [CSIZE-1:0] stall_cnt,
    output logic [CSIZE-1:0] bubble_cnt
);

    localparam logic [CSIZE-1:0] c_cnt_max = {CSIZE{1'b1}};

    logic             r_valid;
    logic             r_sel_mem2reg;
    logic             r_rf_we;
    logic             r_mem_we;
    logic             r_mem_en;
    logic [DSIZE-1:0] r_alu_result;
    logic [DSIZE-1:0] r_store_data;
    logic [RSIZE-1:0] r_rf_dest;
    logic [SSIZE-1:0] r_alu_status;
    logic [CSIZE-1:0] r_stall_cnt;
    logic [CSIZE-1:0] r_bubble_cnt;

    logic w_load;
    logic w_stall_evt;
    logic w_bubble_evt;
    logic w_rs_r0;
    logic w_rt_r0;

    // Flush overrides stall; a load is the only case where inputs are taken.
    assign w_load       = ~stall & ~flush;
    assign w_stall_evt  = stall & ~flush;
    // A bubble enters the stage either by flush or by loading an empty slot.
    assign w_bubble_evt = flush | (w_load & ~valid_i);

    // ------------------------------------------------------------------
    // Pipeline contents. Data fields keep their value on flush so only
    // the control/valid bits are forced to a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid       <= 1'b0;
            r_sel_mem2reg <= 1'b0;
            r_rf_we       <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_en      <= 1'b0;
            r_alu_result  <= '0;
            r_store_data  <= '0;
            r_rf_dest     <= '0;
            r_alu_status  <= '0;
        end else if (flush) begin
            r_valid       <= 1'b0;
            r_sel_mem2reg <= 1'b0;
            r_rf_we       <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_en      <= 1'b0;
        end else if (w_load) begin
            // Controls are gated by valid_i so an invalid slot can never
            // write the RF or memory downstream.
            r_valid       <= valid_i;
            r_sel_mem2reg <= sel_mem2Reg  & valid_i;
            r_rf_we       <= RFwriteEnab  & valid_i;
            r_mem_we      <= memWriteEnab & valid_i;
            r_mem_en      <= memEnab      & valid_i;
            r_alu_result  <= ALUresult;
            r_store_data  <= storeData;
            r_rf_dest     <= RFdest_rd;
            r_alu_status  <= ALUstatus;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters; clear takes priority over increment.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst || cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble_evt && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding match toward EX. Register 0 is hard-wired zero when
    // R0_ZERO is set, so a write to it must never be forwarded.
    // ------------------------------------------------------------------
    assign w_rs_r0    = (R0_ZERO != 0) && (src_rs == '0);
    assign w_rt_r0    = (R0_ZERO != 0) && (src_rt == '0);
    assign fwd_rs_hit = r_valid & r_rf_we & (r_rf_dest == src_rs) & ~w_rs_r0;
    assign fwd_rt_hit = r_valid & r_rf_we & (r_rf_dest == src_rt) & ~w_rt_r0;

    assign valid_o        = r_valid;
    assign sel_mem2Reg_o  = r_sel_mem2reg;
    assign RFwriteEnab_o  = r_rf_we;
    assign memWriteEnab_o = r_mem_we;
    assign memEnab_o      = r_mem_en;
    assign ALUresult_o    = r_alu_result;
    assign storeData_o    = r_store_data;
    assign RFdest_rd_o    = r_rf_dest;
    assign ALUstatus_o    = r_alu_status;
    assign stall_cnt      = r_stall_cnt;
    assign bubble_cnt     = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage_reg
// Purpose  : Self-checking bench for ex_mem_stage_reg (CSIZE=4 so counter
//            saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage_reg;

    localparam int DSIZE = 16;
    localparam int RSIZE = 3;
    localparam int SSIZE = 4;
    localparam int CSIZE = 4;
    localparam int CMAX  = 15;

    logic             Clk = 1'b0;
    logic             Rst, stall, flush, valid_i, cnt_clr;
    logic             sel_mem2Reg, RFwriteEnab, memWriteEnab, memEnab;
    logic [DSIZE-1:0] ALUresult, storeData;
    logic [RSIZE-1:0] RFdest_rd, src_rs, src_rt;
    logic [SSIZE-1:0] ALUstatus;
    logic             valid_o, sel_mem2Reg_o, RFwriteEnab_o, memWriteEnab_o, memEnab_o;
    logic [DSIZE-1:0] ALUresult_o, storeData_o;
    logic [RSIZE-1:0] RFdest_rd_o;
    logic [SSIZE-1:0] ALUstatus_o;
    logic             fwd_rs_hit, fwd_rt_hit;
    logic [CSIZE-1:0] stall_cnt, bubble_cnt;

    always #5 Clk = ~Clk;

    ex_mem_stage_reg #(
        .DSIZE(DSIZE), .RSIZE(RSIZE), .SSIZE(SSIZE), .CSIZE(CSIZE), .R0_ZERO(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .stall(stall), .flush(flush), .valid_i(valid_i),
        .sel_mem2Reg(sel_mem2Reg), .RFwriteEnab(RFwriteEnab),
        .memWriteEnab(memWriteEnab), .memEnab(memEnab),
        .ALUresult(ALUresult), .storeData(storeData), .RFdest_rd(RFdest_rd),
        .ALUstatus(ALUstatus), .src_rs(src_rs), .src_rt(src_rt), .cnt_clr(cnt_clr),
        .valid_o(valid_o), .sel_mem2Reg_o(sel_mem2Reg_o), .RFwriteEnab_o(RFwriteEnab_o),
        .memWriteEnab_o(memWriteEnab_o), .memEnab_o(memEnab_o),
        .ALUresult_o(ALUresult_o), .storeData_o(storeData_o), .RFdest_rd_o(RFdest_rd_o),
        .ALUstatus_o(ALUstatus_o), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the instruction currently held in the Mem slot.
    // Control nibble order: {sel_mem2Reg, RFwriteEnab, memWriteEnab, memEnab}.
    logic             m_valid;
    logic [3:0]       m_ctrl;
    logic [DSIZE-1:0] m_alu, m_store;
    logic [RSIZE-1:0] m_rd;
    logic [SSIZE-1:0] m_status;
    int               m_sc, m_bc;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endfunction

    function automatic logic exp_hit(input logic [RSIZE-1:0] src);
        return m_valid && m_ctrl[2] && (m_rd == src) && (src != 0);
    endfunction

    function automatic logic [3:0] out_ctrl();
        return {sel_mem2Reg_o, RFwriteEnab_o, memWriteEnab_o, memEnab_o};
    endfunction

    task automatic set_in(input logic st, input logic fl, input logic vl, input logic [3:0] c,
                          input logic [DSIZE-1:0] alu, input logic [RSIZE-1:0] rd,
                          input logic [RSIZE-1:0] rs, input logic [RSIZE-1:0] rt);
        stall = st; flush = fl; valid_i = vl;
        {sel_mem2Reg, RFwriteEnab, memWriteEnab, memEnab} = c;
        ALUresult = alu; storeData = ~alu; ALUstatus = alu[3:0] ^ 4'h5;
        RFdest_rd = rd; src_rs = rs; src_rt = rt;
    endtask

    // Apply the stage rules for one rising edge to the model.
    task automatic model_edge();
        int sc_inc, bc_inc;
        if (Rst) begin
            m_valid = 0; m_ctrl = 0; m_alu = 0; m_store = 0; m_rd = 0; m_status = 0;
            m_sc = 0; m_bc = 0;
        end else begin
            sc_inc = (stall && !flush) ? 1 : 0;
            bc_inc = (flush || (!stall && !valid_i)) ? 1 : 0;
            if (flush) begin
                m_valid = 0; m_ctrl = 0;
            end else if (!stall) begin
                m_valid  = valid_i;
                m_ctrl   = valid_i ? {sel_mem2Reg, RFwriteEnab, memWriteEnab, memEnab} : 4'h0;
                m_alu    = ALUresult; m_store = storeData;
                m_rd     = RFdest_rd; m_status = ALUstatus;
            end
            if (cnt_clr) begin
                m_sc = 0; m_bc = 0;
            end else begin
                m_sc = (m_sc + sc_inc > CMAX) ? CMAX : m_sc + sc_inc;
                m_bc = (m_bc + bc_inc > CMAX) ? CMAX : m_bc + bc_inc;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  {31'd0, valid_o},  {31'd0, m_valid});
        check({tag, ".ctrl"},   {28'd0, out_ctrl()}, {28'd0, m_ctrl});
        check({tag, ".alu"},    {16'd0, ALUresult_o}, {16'd0, m_alu});
        check({tag, ".store"},  {16'd0, storeData_o}, {16'd0, m_store});
        check({tag, ".rd"},     {29'd0, RFdest_rd_o}, {29'd0, m_rd});
        check({tag, ".status"}, {28'd0, ALUstatus_o}, {28'd0, m_status});
        check({tag, ".fwd_rs"}, {31'd0, fwd_rs_hit}, {31'd0, exp_hit(src_rs)});
        check({tag, ".fwd_rt"}, {31'd0, fwd_rt_hit}, {31'd0, exp_hit(src_rt)});
        check({tag, ".stall_cnt"},  {28'd0, stall_cnt},  m_sc);
        check({tag, ".bubble_cnt"}, {28'd0, bubble_cnt}, m_bc);
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic             st, fl, vl;
        logic [3:0]       c;
        logic [DSIZE-1:0] alu;
        logic [RSIZE-1:0] rd, rs, rt;
        logic             e_valid;
        logic [3:0]       e_ctrl;
        logic [DSIZE-1:0] e_alu;
        logic [RSIZE-1:0] e_rd;
        logic             e_hrs, e_hrt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        //          st fl vl ctrl    alu       rd  rs  rt   valid ctrl   alu       rd  hrs hrt
        tbl[0]  = '{0, 0, 1, 4'h4, 16'hBEEF, 3'd5, 3'd5, 3'd2, 1, 4'h4, 16'hBEEF, 3'd5, 1, 0};
        tbl[1]  = '{0, 0, 1, 4'h4, 16'h1234, 3'd3, 3'd3, 3'd2, 1, 4'h4, 16'h1234, 3'd3, 1, 0};
        tbl[2]  = '{1, 0, 1, 4'h4, 16'h5678, 3'd4, 3'd3, 3'd3, 1, 4'h4, 16'h1234, 3'd3, 1, 1};
        tbl[3]  = '{1, 0, 1, 4'h4, 16'h5678, 3'd4, 3'd3, 3'd3, 1, 4'h4, 16'h1234, 3'd3, 1, 1};
        tbl[4]  = '{1, 0, 1, 4'h4, 16'h5678, 3'd4, 3'd3, 3'd3, 1, 4'h4, 16'h1234, 3'd3, 1, 1};
        tbl[5]  = '{0, 0, 1, 4'h6, 16'h5678, 3'd4, 3'd4, 3'd0, 1, 4'h6, 16'h5678, 3'd4, 1, 0};
        tbl[6]  = '{1, 1, 1, 4'hF, 16'h9999, 3'd1, 3'd4, 3'd4, 0, 4'h0, 16'h5678, 3'd4, 0, 0};
        tbl[7]  = '{0, 0, 0, 4'h5, 16'h00FF, 3'd1, 3'd1, 3'd1, 0, 4'h0, 16'h00FF, 3'd1, 0, 0};
        tbl[8]  = '{0, 0, 1, 4'h4, 16'h0000, 3'd0, 3'd0, 3'd0, 1, 4'h4, 16'h0000, 3'd0, 0, 0};
        tbl[9]  = '{0, 0, 1, 4'h0, 16'h1111, 3'd6, 3'd6, 3'd6, 1, 4'h0, 16'h1111, 3'd6, 0, 0};
        tbl[10] = '{0, 0, 1, 4'hF, 16'hABCD, 3'd7, 3'd2, 3'd7, 1, 4'hF, 16'hABCD, 3'd7, 0, 1};
        tbl[11] = '{0, 1, 1, 4'hF, 16'h2222, 3'd2, 3'd2, 3'd7, 0, 4'h0, 16'hABCD, 3'd7, 0, 0};

        m_valid = 0; m_ctrl = 0; m_alu = 0; m_store = 0; m_rd = 0; m_status = 0;
        m_sc = 0; m_bc = 0;

        // Reset with busy inputs: every output must read 0.
        Rst = 1; cnt_clr = 0;
        set_in(1'b0, 1'b0, 1'b1, 4'hF, 16'hBEEF, 3'd5, 3'd5, 3'd5);
        cycle("reset1");
        cycle("reset2");
        check("reset.alu_zero", {16'd0, ALUresult_o}, 32'd0);
        check("reset.valid_zero", {31'd0, valid_o}, 32'd0);
        Rst = 0;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].st, tbl[i].fl, tbl[i].vl, tbl[i].c, tbl[i].alu, tbl[i].rd, tbl[i].rs, tbl[i].rt);
            cycle($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d.ctrl", i), {28'd0, out_ctrl()}, {28'd0, tbl[i].e_ctrl});
            check($sformatf("tbl%0d.alu", i), {16'd0, ALUresult_o}, {16'd0, tbl[i].e_alu});
            check($sformatf("tbl%0d.rd", i), {29'd0, RFdest_rd_o}, {29'd0, tbl[i].e_rd});
            check($sformatf("tbl%0d.hit_rs", i), {31'd0, fwd_rs_hit}, {31'd0, tbl[i].e_hrs});
            check($sformatf("tbl%0d.hit_rt", i), {31'd0, fwd_rt_hit}, {31'd0, tbl[i].e_hrt});
        end
        // 3 stall-only cycles; bubbles from flush+stall, invalid load, flush.
        check("tbl.stall_cnt", {28'd0, stall_cnt}, 32'd3);
        check("tbl.bubble_cnt", {28'd0, bubble_cnt}, 32'd3);

        // Stall counter saturation, then clear under stall.
        set_in(1'b1, 1'b0, 1'b1, 4'hF, 16'h7777, 3'd3, 3'd7, 3'd7);
        for (int i = 0; i < 20; i++) cycle("sat_stall");
        check("sat.stall_cnt", {28'd0, stall_cnt}, 32'd15);
        check("sat.alu_held", {16'd0, ALUresult_o}, 32'hABCD);
        cnt_clr = 1;
        cycle("clr");
        check("clr.stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check("clr.bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
        check("clr.alu_held", {16'd0, ALUresult_o}, 32'hABCD);
        cnt_clr = 0;

        // Bubble counter saturation via repeated flush.
        set_in(1'b0, 1'b1, 1'b1, 4'hF, 16'h3333, 3'd3, 3'd3, 3'd3);
        for (int i = 0; i < 20; i++) cycle("sat_flush");
        check("sat.bubble_cnt", {28'd0, bubble_cnt}, 32'd15);

        // Reset mid-stall leaves a bubble once released.
        set_in(1'b0, 1'b0, 1'b1, 4'h4, 16'h4444, 3'd2, 3'd2, 3'd1);
        cycle("pre_rst_load");
        stall = 1; Rst = 1;
        cycle("rst_mid_stall");
        Rst = 0;
        cycle("post_rst_stall");
        check("post_rst.valid", {31'd0, valid_o}, 32'd0);
        check("post_rst.alu", {16'd0, ALUresult_o}, 32'd0);

        // Randomized run against the model, including mid-cycle src changes.
        for (int i = 0; i < 3000; i++) begin
            Rst     = ($urandom_range(99) == 0);
            cnt_clr = ($urandom_range(63) == 0);
            set_in($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                   4'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            cycle("rand");
            src_rs = 3'($urandom_range(1) ? m_rd : 3'($urandom));
            src_rt = 3'($urandom);
            #1;
            check("rand.comb_rs", {31'd0, fwd_rs_hit}, {31'd0, exp_hit(src_rs)});
            check("rand.comb_rt", {31'd0, fwd_rt_hit}, {31'd0, exp_hit(src_rt)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
